// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues word addresses to a 1-cycle synchronous memory
// and buffers returned instructions in a 2-entry FIFO with valid/ready handoff.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC    = 32'd0,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [7:0]  HALT_OPCODE = 8'h0F
) (
  input  logic        CLK,
  input  logic        RESET_N,
  output logic [31:0] ADDRESS,
  input  logic [31:0] INST,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  output logic [31:0] INST_OUT,
  output logic [31:0] PC_OUT,
  output logic        VALID,
  input  logic        READY,
  output logic        HALTED
);

  localparam logic [31:0] PC_MASK = 32'(DEPTH_WORDS - 1);

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        inflight_q, inflight_d;
  logic [31:0] inflight_pc_q, inflight_pc_d;
  logic [31:0] head_inst_q, head_inst_d, head_pc_q, head_pc_d;
  logic [31:0] tail_inst_q, tail_inst_d, tail_pc_q, tail_pc_d;
  logic [1:0]  count_q, count_d;
  logic        halt_pending_q, halt_pending_d;
  logic        halted_q, halted_d;

  logic        xfer, flush, issue, push, halt_xfer;
  logic [2:0]  occupancy;
  logic [1:0]  cnt;

  always_comb begin
    xfer      = (count_q != 2'd0) && READY;
    flush     = BRANCH_TAKEN && !halted_q;
    halt_xfer = xfer && (head_inst_q[31:24] == HALT_OPCODE);
    // Entries that will occupy the FIFO once the current in-flight word lands.
    occupancy = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, xfer};
    issue     = !halted_q && !halt_pending_q && !BRANCH_TAKEN && (occupancy <= 3'd1);
    // Words fetched behind a HALT are dropped on return.
    push      = inflight_q && !flush && !halt_pending_q;

    fetch_pc_d     = fetch_pc_q;
    inflight_d     = issue;
    inflight_pc_d  = inflight_pc_q;
    head_inst_d    = head_inst_q;
    head_pc_d      = head_pc_q;
    tail_inst_d    = tail_inst_q;
    tail_pc_d      = tail_pc_q;
    halt_pending_d = halt_pending_q;
    halted_d       = halted_q | halt_xfer;
    cnt            = count_q;

    if (flush) begin
      fetch_pc_d = BRANCH_TARGET & PC_MASK;
    end else if (issue) begin
      fetch_pc_d    = (fetch_pc_q + 32'd1) & PC_MASK;
      inflight_pc_d = fetch_pc_q;
    end

    if (xfer) begin
      head_inst_d = tail_inst_q;
      head_pc_d   = tail_pc_q;
      cnt         = count_q - 2'd1;
    end
    if (push) begin
      if (cnt == 2'd0) begin
        head_inst_d = INST;
        head_pc_d   = inflight_pc_q;
      end else begin
        tail_inst_d = INST;
        tail_pc_d   = inflight_pc_q;
      end
      cnt = cnt + 2'd1;
      if (INST[31:24] == HALT_OPCODE) halt_pending_d = 1'b1;
    end
    count_d = cnt;

    if (flush || halt_xfer) begin
      count_d        = 2'd0;
      halt_pending_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      fetch_pc_q     <= RESET_PC;
      inflight_q     <= 1'b0;
      inflight_pc_q  <= '0;
      head_inst_q    <= '0;
      head_pc_q      <= '0;
      tail_inst_q    <= '0;
      tail_pc_q      <= '0;
      count_q        <= 2'd0;
      halt_pending_q <= 1'b0;
      halted_q       <= 1'b0;
    end else begin
      fetch_pc_q     <= fetch_pc_d;
      inflight_q     <= inflight_d;
      inflight_pc_q  <= inflight_pc_d;
      head_inst_q    <= head_inst_d;
      head_pc_q      <= head_pc_d;
      tail_inst_q    <= tail_inst_d;
      tail_pc_q      <= tail_pc_d;
      count_q        <= count_d;
      halt_pending_q <= halt_pending_d;
      halted_q       <= halted_d;
    end
  end

  assign ADDRESS  = fetch_pc_q;
  assign INST_OUT = head_inst_q;
  assign PC_OUT   = head_pc_q;
  assign VALID    = (count_q != 2'd0);
  assign HALTED   = halted_q;

endmodule
